// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

  localparam int DEV_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  function automatic int tmr_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
module rr_priority_select #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] c;

  // Scan from farthest to nearest so the slot closest to the pointer wins.
  always_comb begin
    any_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    c     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= N_L) sum = sum - N_L;
      c = sum[IDX_W-1:0];
      if (req_i[c]) begin
        any_o    = 1'b1;
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin sharing of one memory request port; one transaction in flight,
// grant held until done, watchdog abort with sticky exception.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DEV_W-1:0]    req_dev_i,
  input  logic [N_REQ-1:0]          req_block_i,
  input  logic [N_REQ-1:0]          req_rw_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_add_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          req_valid_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic [N_REQ-1:0]          req_done_o,
  output logic [N_REQ-1:0]          req_err_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_done_i,
  input  logic                      mem_valid_i,
  input  logic [DATA_W-1:0]         mem_data_i,
  output logic [DEV_W-1:0]          mem_reqdev_o,
  output logic                      mem_req_o,
  output logic                      mem_req_block_o,
  output logic                      mem_rw_o,
  output logic [ADDR_W-1:0]         mem_add_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      exception_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = tmr_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             exc_q, exc_d;

  logic             sel_any;
  logic [N_REQ-1:0] sel_gnt;
  logic [IDX_W-1:0] sel_idx;
  logic             done_evt, tmo_evt;

  rr_priority_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_sel (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (sel_any),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx)
  );

  // A done arriving on the last allowed cycle still completes cleanly.
  assign done_evt = (state_q == WAIT) && mem_done_i;
  assign tmo_evt  = (state_q != IDLE) && (tmr_q == TMR_LAST) && !done_evt;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: if (sel_any) begin
        state_d = ISSUE;
        gnt_d   = sel_gnt;
        gidx_d  = sel_idx;
        tmr_d   = '0;
      end
      ISSUE: begin
        tmr_d = tmr_q + 1'b1;
        if (mem_ready_i) state_d = WAIT;
      end
      WAIT:    tmr_d = tmr_q + 1'b1;
      default: state_d = IDLE;
    endcase
    if (done_evt || tmo_evt) begin
      state_d = IDLE;
      gnt_d   = '0;
      tmr_d   = '0;
      ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
    end
    if (tmo_evt) exc_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      tmr_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      exc_q   <= exc_d;
    end
  end

  // gnt_q is all-zero in IDLE, so the muxes fall to zero without a grant.
  always_comb begin
    mem_reqdev_o    = '0;
    mem_req_block_o = 1'b0;
    mem_rw_o        = 1'b0;
    mem_add_o       = '0;
    mem_data_o      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        mem_reqdev_o    = req_dev_i[i*DEV_W +: DEV_W];
        mem_req_block_o = req_block_i[i];
        mem_rw_o        = req_rw_i[i];
        mem_add_o       = req_add_i[i*ADDR_W +: ADDR_W];
        mem_data_o      = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_req_o   = (state_q == ISSUE);
  assign gnt_o       = gnt_q;
  assign req_valid_o = (state_q == WAIT && mem_valid_i) ? gnt_q : '0;
  assign req_rdata_o = (state_q == WAIT) ? mem_data_i : '0;
  assign req_done_o  = (done_evt || tmo_evt) ? gnt_q : '0;
  assign req_err_o   = tmo_evt ? gnt_q : '0;
  assign exception_o = exc_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized self-checking bench for mem_request_arbiter against a round-robin model.
module tb_mem_request_arbiter;

  localparam int N  = 3;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [N-1:0] ONE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*3-1:0]  dev;
  logic [N-1:0]  blk, rw;
  logic [N*AW-1:0] add;
  logic [N*DW-1:0] wd;
  logic          mem_ready, mem_done, mem_valid;
  logic [DW-1:0] mem_rdata;

  logic [N-1:0]  gnt, rvalid, rdone, rerr;
  logic [DW-1:0] rdata, m_wdata;
  logic [2:0]    m_dev;
  logic          m_req, m_blk, m_rw, exc;
  logic [AW-1:0] m_add;

  logic [2:0]    dev_a [N];
  logic [AW-1:0] add_a [N];
  logic [DW-1:0] wd_a  [N];
  logic          rw_a  [N];
  logic          blk_a [N];

  int checks = 0;
  int passed = 0;
  int ptr_m  = 0;

  always #5 clk = ~clk;

  always_comb begin
    dev = '0; add = '0; wd = '0; rw = '0; blk = '0;
    for (int i = 0; i < N; i++) begin
      dev[i*3 +: 3]   = dev_a[i];
      add[i*AW +: AW] = add_a[i];
      wd[i*DW +: DW]  = wd_a[i];
      rw[i]           = rw_a[i];
      blk[i]          = blk_a[i];
    end
  end

  mem_request_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst),
    .req_i(req), .req_dev_i(dev), .req_block_i(blk), .req_rw_i(rw),
    .req_add_i(add), .req_data_i(wd),
    .gnt_o(gnt), .req_valid_o(rvalid), .req_rdata_o(rdata),
    .req_done_o(rdone), .req_err_o(rerr),
    .mem_ready_i(mem_ready), .mem_done_i(mem_done), .mem_valid_i(mem_valid),
    .mem_data_i(mem_rdata),
    .mem_reqdev_o(m_dev), .mem_req_o(m_req), .mem_req_block_o(m_blk),
    .mem_rw_o(m_rw), .mem_add_o(m_add), .mem_data_o(m_wdata),
    .exception_o(exc)
  );

  // Model: next grant is the first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = r >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_attr(input int i);
    dev_a[i] = 3'($urandom);
    add_a[i] = AW'($urandom);
    wd_a[i]  = DW'($urandom);
    rw_a[i]  = 1'($urandom);
    blk_a[i] = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic go_wait();
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
  endtask

  task automatic finish_txn();
    mem_done = 1'b1; tick(); mem_done = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) rand_attr(i);
    rst = 1'b1; req = '1;
    mem_ready = 1'b1; mem_done = 1'b0; mem_valid = 1'b1; mem_rdata = '1;
    tick(); tick();
    checks++;
    if ({gnt, rvalid, rdone, rerr, rdata, m_dev, m_req, m_blk, m_rw, m_add, m_wdata, exc} !== '0)
      $display("FAIL reset_outputs: gnt=%b mreq=%b add=%h exc=%b, expected all zero", gnt, m_req, m_add, exc);
    else passed++;
    req = '0; mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    rst = 1'b0; ptr_m = 0;
    tick();
    checks++;
    if (gnt !== '0 || m_req !== 1'b0) $display("FAIL reset_idle: gnt=%b mreq=%b, expected 0", gnt, m_req);
    else passed++;
  endtask

  task automatic test_single_read();
    int nv = 0;
    rand_attr(0); rw_a[0] = 1'b0; blk_a[0] = 1'b0;
    req = 3'b001; #1;
    checks++;
    if (m_req !== 1'b0) $display("FAIL read_latency_early: mem_req=%b expected 0", m_req); else passed++;
    tick();
    checks++;
    if (m_req !== 1'b1 || gnt !== 3'b001) $display("FAIL read_issue: mem_req=%b gnt=%b expected 1/001", m_req, gnt);
    else passed++;
    checks++;
    if (m_add !== add_a[0] || m_dev !== dev_a[0] || m_rw !== 1'b0)
      $display("FAIL read_attr: add=%h dev=%h rw=%b expected %h %h 0", m_add, m_dev, m_rw, add_a[0], dev_a[0]);
    else passed++;
    go_wait();
    checks++;
    if (m_req !== 1'b0) $display("FAIL read_req_drop: mem_req=%b expected 0", m_req); else passed++;
    for (int v = 0; v < 2; v++) begin
      mem_valid = 1'b1; mem_rdata = $urandom; #1;
      if (rvalid === 3'b001) nv++;
      checks++;
      if (rdata !== mem_rdata) $display("FAIL read_data: got %h expected %h", rdata, mem_rdata); else passed++;
      tick();
    end
    mem_valid = 1'b0; #1;
    checks++;
    if (nv != 2 || rvalid !== '0) $display("FAIL read_valid_count: got %0d (now %b) expected 2", nv, rvalid); else passed++;
    mem_done = 1'b1; #1;
    checks++;
    if (rdone !== 3'b001 || rerr !== '0) $display("FAIL read_done: done=%b err=%b expected 001/000", rdone, rerr);
    else passed++;
    tick(); mem_done = 1'b0; req = '0; #1;
    checks++;
    if (rdone !== '0 || gnt !== '0) $display("FAIL read_after_done: done=%b gnt=%b expected 0", rdone, gnt); else passed++;
    ptr_m = 1;
  endtask

  task automatic test_alternate();
    int exp_seq [4] = '{0, 1, 0, 1};
    do_reset();
    req = 3'b011;
    for (int t = 0; t < 4; t++) begin
      int g = pick(req, ptr_m);
      for (int c = 0; c < 8 && gnt === '0; c++) tick();
      checks++;
      if (gnt !== (ONE << exp_seq[t])) $display("FAIL alt_order[%0d]: gnt=%b expected %b", t, gnt, ONE << exp_seq[t]);
      else passed++;
      checks++;
      if (gnt !== (ONE << g)) $display("FAIL alt_model[%0d]: gnt=%b expected %b", t, gnt, ONE << g); else passed++;
      go_wait(); finish_txn();
      ptr_m = (g + 1) % N;
    end
    req = '0; tick();
  endtask

  task automatic test_ready_stall();
    rand_attr(0);
    req = 3'b001;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) mem_ready = 1'b1;
      #1;
      checks++;
      if (m_req !== 1'b1 || gnt !== 3'b001 || m_add !== add_a[0] || m_rw !== rw_a[0])
        $display("FAIL stall[%0d]: mreq=%b gnt=%b add=%h rw=%b expected 1 001 %h %b", k, m_req, gnt, m_add, m_rw, add_a[0], rw_a[0]);
      else passed++;
      tick();
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (m_req !== 1'b0) $display("FAIL stall_release: mem_req=%b expected 0", m_req); else passed++;
    finish_txn(); req = '0;
    ptr_m = 1;
  endtask

  task automatic test_block_write();
    rand_attr(1); rw_a[1] = 1'b1; blk_a[1] = 1'b1;
    req = 3'b010;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    checks++;
    if (gnt !== 3'b010 || m_blk !== 1'b1 || m_rw !== 1'b1)
      $display("FAIL blk_issue: gnt=%b blk=%b rw=%b expected 010 1 1", gnt, m_blk, m_rw);
    else passed++;
    go_wait();
    for (int k = 0; k < 4; k++) begin
      wd_a[1] = $urandom; wd_a[0] = ~wd_a[1]; #1;
      checks++;
      if (m_wdata !== wd_a[1]) $display("FAIL blk_data[%0d]: got %h expected %h", k, m_wdata, wd_a[1]); else passed++;
      tick();
    end
    finish_txn(); req = '0;
    ptr_m = 2;
  endtask

  task automatic test_random();
    req = '0;
    for (int r = 0; r < 30; r++) begin
      int g, d, nv;
      if (req == '0) begin
        g = $urandom_range(0, N - 1);
        rand_attr(g);
        req = ONE << g;
      end
      g = pick(req, ptr_m);
      for (int c = 0; c < 8 && gnt === '0; c++) tick();
      checks++;
      if (gnt !== (ONE << g)) $display("FAIL rnd_gnt[%0d]: gnt=%b expected %b", r, gnt, ONE << g); else passed++;
      checks++;
      if (m_add !== add_a[g] || m_dev !== dev_a[g] || m_rw !== rw_a[g] || m_blk !== blk_a[g])
        $display("FAIL rnd_attr[%0d]: add=%h dev=%h expected %h %h", r, m_add, m_dev, add_a[g], dev_a[g]);
      else passed++;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) tick();
      go_wait();
      nv = $urandom_range(0, 3);
      for (int v = 0; v < nv; v++) begin
        mem_valid = 1'b1; mem_rdata = $urandom; #1;
        checks++;
        if (rvalid !== (ONE << g) || rdata !== mem_rdata)
          $display("FAIL rnd_valid[%0d]: valid=%b data=%h expected %b %h", r, rvalid, rdata, ONE << g, mem_rdata);
        else passed++;
        tick();
      end
      mem_valid = 1'b0; mem_done = 1'b1; #1;
      checks++;
      if (rdone !== (ONE << g) || rerr !== '0) $display("FAIL rnd_done[%0d]: done=%b err=%b expected %b 000", r, rdone, rerr, ONE << g);
      else passed++;
      tick(); mem_done = 1'b0;
      ptr_m = (g + 1) % N;
      rand_attr(g);
      req = (req & ~(ONE << g)) | N'($urandom);
      for (int i = 0; i < N; i++) if (((req >> i) & ONE) != 0 && i != g && gnt === '0) ;
    end
    req = '0; tick();
  endtask

  task automatic test_timeout();
    rand_attr(0);
    req = 3'b001;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    for (int k = 0; k < TO; k++) begin
      mem_ready = (k == 0); #1;
      checks++;
      if (rdone !== ((k == TO - 1) ? 3'b001 : 3'b000) || rerr !== rdone)
        $display("FAIL tmo_cycle[%0d]: done=%b err=%b expected pulse only at %0d", k, rdone, rerr, TO - 1);
      else passed++;
      tick();
    end
    req = '0; #1;
    checks++;
    if (exc !== 1'b1 || gnt !== '0) $display("FAIL tmo_exc: exc=%b gnt=%b expected 1 000", exc, gnt); else passed++;
    ptr_m = 1;
    tick();
    req = 3'b001;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    for (int k = 0; k < TO - 1; k++) begin
      mem_ready = (k == 0); tick();
    end
    mem_done = 1'b1; #1;
    checks++;
    if (rdone !== 3'b001 || rerr !== 3'b000) $display("FAIL done_wins: done=%b err=%b expected 001 000", rdone, rerr);
    else passed++;
    tick(); mem_done = 1'b0; req = '0; #1;
    checks++;
    if (exc !== 1'b1) $display("FAIL exc_sticky: exc=%b expected 1", exc); else passed++;
    ptr_m = 1;
  endtask

  task automatic test_reset_mid();
    req = 3'b001;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    go_wait(); finish_txn();
    ptr_m = 1;
    req = 3'b011;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    checks++;
    if (gnt !== (ONE << pick(req, ptr_m))) $display("FAIL mid_gnt: gnt=%b expected %b", gnt, ONE << pick(req, ptr_m));
    else passed++;
    go_wait();
    rst = 1'b1; tick();
    checks++;
    if ({gnt, rvalid, rdone, rerr, rdata, m_dev, m_req, m_blk, m_rw, m_add, m_wdata, exc} !== '0)
      $display("FAIL mid_reset_outputs: gnt=%b done=%b exc=%b add=%h expected all zero", gnt, rdone, exc, m_add);
    else passed++;
    rst = 1'b0; ptr_m = 0;
    for (int c = 0; c < 8 && gnt === '0; c++) tick();
    checks++;
    if (gnt !== (ONE << pick(req, ptr_m))) $display("FAIL mid_regrant: gnt=%b expected %b", gnt, ONE << pick(req, ptr_m));
    else passed++;
    go_wait(); finish_txn(); req = '0; tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_ready_stall();
    test_block_write();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
